plot_receiver: RTL
==================

Name: plot_receiver

Overview:
- Consumer end of the pixel-plot interface driven by the display datapaths: accepts (x, y, colour, plot) write requests.
- Clips out-of-range pixels and converts coordinates to a linear framebuffer address (y*WIDTH + x).
- Buffers requests in a small FIFO and drains them to the framebuffer RAM write port under a ready handshake.
- Also provides a full-screen clear sweep, so datapaths never have to iterate the whole frame themselves.

Parameters:
- WIDTH, 320, screen width in pixels.
- HEIGHT, 240, screen height in pixels.
- FIFO_DEPTH, 4, request buffer entries (power of two, >= 2).
- COLOUR_BITS, 3, colour width.
- ADDR_BITS, 17, framebuffer address width (must hold WIDTH*HEIGHT-1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- plot  in  1  write request valid.
- x  in  9  pixel column.
- y  in  8  pixel row.
- colour  in  COLOUR_BITS  pixel colour.
- ready  out  1  request can be accepted this cycle.
- clearScreen  in  1  one-cycle clear request.
- clearColour  in  COLOUR_BITS  fill colour, sampled with clearScreen.
- busy  out  1  clear pending or in progress.
- memWrite  out  1  RAM write strobe.
- memAddress  out  ADDR_BITS  RAM write address.
- memData  out  COLOUR_BITS  RAM write data.
- memReady  in  1  RAM accepts the write this cycle.
- dropCount  out  16  saturating count of clipped plots.

Behaviour:
- Reset (async, immediate), all zero:
  - state=RUN, stage1 invalid, FIFO empty, dropCount=0, clear counter=0.
  - memWrite=0, memAddress=0, memData=0, busy=0.
  - ready recovers to 1 on the first cycle after reset deasserts.
- Handshake:
  - A plot is accepted when plot && ready at the rising edge.
  - ready = (state==RUN) && (fifoCount + stage1Valid < FIFO_DEPTH). Combinational from registered state only; does not depend on memReady.
- Clipping:
  - An accepted plot with x >= WIDTH or y >= HEIGHT is discarded; it never enters stage1 or the FIFO.
  - dropCount increments by 1 and saturates at 16'hFFFF.
- Stage1 (1 cycle):
  - Registers address = y*WIDTH + x, computed at ADDR_BITS width with no truncation. For WIDTH=320, use (y<<8)+(y<<6)+x; no multiplier.
  - Also registers colour.
  - A valid stage1 entry pushes into the FIFO on the next edge.
- FIFO:
  - First-word order is preserved.
  - Push and pop may occur in the same cycle, including when full or empty.
  - Pop when memWrite && memReady.
- Latency: plot accepted at edge k -> stage1 valid after k -> FIFO head after k+1 -> memWrite=1 in the cycle after edge k+1 (2-cycle minimum latency).
- Outputs in RUN:
  - memWrite = FIFO non-empty; memAddress/memData = FIFO head.
  - Values hold stable while memReady=0.
- FSM states:
  - RUN: normal operation. clearScreen=1 latches clearColour and goes to DRAIN. A plot in the same cycle is accepted first (it precedes the clear).
  - DRAIN: ready=0, busy=1. Move to CLEAR when stage1 is invalid and the FIFO is empty.
  - CLEAR: ready=0, busy=1, memWrite=1, memAddress=clear counter, memData=latched colour. Counter advances on memReady. After the write of WIDTH*HEIGHT-1 is accepted, counter resets to 0 and state returns to RUN.
  - clearScreen while in DRAIN or CLEAR is ignored.
- Reset mid-clear: the sweep is abandoned; state returns to RUN with an empty FIFO.

Decomposition:
- Shared package (display_pkg):
  - WIDTH, HEIGHT, ADDR_BITS, COLOUR_BITS constants.
  - FSM state enum (RUN, DRAIN, CLEAR).
  - Address function xy_to_addr.
- Sub-module pixel_fifo:
  - Parameterised depth/width synchronous FIFO with push, pop, count, full, empty.
  - Async active-high reset.
  - Reusable by other display datapaths.

Test Plan:
- Single plot (5,2) colour 3'b101, memReady=1 -> exactly one memWrite, 2 cycles after acceptance, memAddress=645, memData=3'b101.
- Corners (0,0), (319,239), (319,0) with memReady=1 -> addresses 0, 76799, 319 in order; dropCount=0.
- Clip: plots (320,0), (0,240), (511,255) -> no memWrite; dropCount=3; ready stays 1.
- Backpressure: memReady=0, plot held high -> exactly 4 accepted (stage1+FIFO total=4), then ready=0. Release memReady -> 4 writes in input order, then ready=1.
- Clear: clearScreen with clearColour=3'b001 while 2 plots are queued -> the 2 plot writes first, then 76800 writes at addresses 0..76799 with data 3'b001. busy=1 throughout; ready=1 and busy=0 afterwards. Toggle memReady randomly; no address may be skipped or repeated.
- Reset asserted mid-CLEAR (counter about 1000) -> outputs zero immediately. After release: RUN, ready=1, busy=0, dropCount=0, no further clear writes.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants, plot-receiver FSM states and address mapping.
package display_pkg;

    localparam int DISP_WIDTH       = 320;
    localparam int DISP_HEIGHT      = 240;
    localparam int DISP_ADDR_BITS   = 17;
    localparam int DISP_COLOUR_BITS = 3;
    localparam int DISP_X_BITS      = 9;
    localparam int DISP_Y_BITS      = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // y*320 + x as two shifts and adds; operands widened first so nothing is truncated.
    function automatic logic [DISP_ADDR_BITS-1:0] xy_to_addr(
        input logic [DISP_X_BITS-1:0] x,
        input logic [DISP_Y_BITS-1:0] y
    );
        logic [DISP_ADDR_BITS-1:0] xe;
        logic [DISP_ADDR_BITS-1:0] ye;
        xe = {{(DISP_ADDR_BITS-DISP_X_BITS){1'b0}}, x};
        ye = {{(DISP_ADDR_BITS-DISP_Y_BITS){1'b0}}, y};
        return (ye << 8) + (ye << 6) + xe;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - parameterised synchronous FIFO with simultaneous push/pop at any fill level.
module pixel_fifo #(
    parameter int DEPTH     = 4,
    parameter int DATA_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_BITS-1:0]   push_data,
    input  logic                   pop,
    output logic [DATA_BITS-1:0]   pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == DEPTH_CNT);
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// rtl/plot_receiver.sv - clips and addresses pixel plots, queues them to the framebuffer, runs full-screen clears.
module plot_receiver
    import display_pkg::*;
#(
    parameter int WIDTH       = DISP_WIDTH,
    parameter int HEIGHT      = DISP_HEIGHT,
    parameter int FIFO_DEPTH  = 4,
    parameter int COLOUR_BITS = DISP_COLOUR_BITS,
    parameter int ADDR_BITS   = DISP_ADDR_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   plot,
    input  logic [8:0]             x,
    input  logic [7:0]             y,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic                   ready,
    input  logic                   clearScreen,
    input  logic [COLOUR_BITS-1:0] clearColour,
    output logic                   busy,
    output logic                   memWrite,
    output logic [ADDR_BITS-1:0]   memAddress,
    output logic [COLOUR_BITS-1:0] memData,
    input  logic                   memReady,
    output logic [15:0]            dropCount
);

    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_BITS = ADDR_BITS + COLOUR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W:0]       DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    state_t                 state_q, state_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ADDR_BITS-1:0]   s1_addr_q, s1_addr_d;
    logic [COLOUR_BITS-1:0] s1_colour_q, s1_colour_d;
    logic [COLOUR_BITS-1:0] clr_colour_q, clr_colour_d;
    logic [ADDR_BITS-1:0]   clr_cnt_q, clr_cnt_d;
    logic [15:0]            drop_q, drop_d;

    logic [ENTRY_BITS-1:0]  fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [CNT_W:0]         occupancy;
    logic                   accept;
    logic                   in_range;
    logic [ADDR_BITS-1:0]   plot_addr;

    pixel_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .DATA_BITS (ENTRY_BITS)
    ) u_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (s1_valid_q),
        .push_data ({s1_addr_q, s1_colour_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stage1 counts against capacity so an accepted plot always has a FIFO slot waiting for it.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
    assign ready     = (state_q == RUN) && !fifo_full && (occupancy < DEPTH_LIM);
    assign accept    = plot && ready;
    assign in_range  = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign busy      = (state_q != RUN);
    assign dropCount = drop_q;

    always_comb begin
        if (WIDTH == 320 && ADDR_BITS == DISP_ADDR_BITS) begin
            plot_addr = ADDR_BITS'(xy_to_addr(x, y));
        end else begin
            plot_addr = ADDR_BITS'(y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(x);
        end
    end

    always_comb begin
        state_d      = state_q;
        s1_valid_d   = 1'b0;
        s1_addr_d    = s1_addr_q;
        s1_colour_d  = s1_colour_q;
        clr_colour_d = clr_colour_q;
        clr_cnt_d    = clr_cnt_q;
        drop_d       = drop_q;
        memWrite     = 1'b0;
        memAddress   = '0;
        memData      = '0;
        fifo_pop     = 1'b0;

        if (accept) begin
            if (in_range) begin
                s1_valid_d  = 1'b1;
                s1_addr_d   = plot_addr;
                s1_colour_d = colour;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end

        // Queued plots keep draining during DRAIN so the clear starts behind them.
        if (state_q != CLEAR && !fifo_empty) begin
            memWrite   = 1'b1;
            memAddress = fifo_head[ENTRY_BITS-1:COLOUR_BITS];
            memData    = fifo_head[COLOUR_BITS-1:0];
            fifo_pop   = memReady;
        end

        case (state_q)
            RUN: begin
                if (clearScreen) begin
                    clr_colour_d = clearColour;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q && fifo_empty) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                memWrite   = 1'b1;
                memAddress = clr_cnt_q;
                memData    = clr_colour_q;
                if (memReady) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_cnt_d = '0;
                        state_d   = RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_colour_q  <= '0;
            clr_colour_q <= '0;
            clr_cnt_q    <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_colour_q  <= s1_colour_d;
            clr_colour_q <= clr_colour_d;
            clr_cnt_q    <= clr_cnt_d;
            drop_q       <= drop_d;
        end
    end

endmodule
